long_division_arbiter: RTL and testbench
========================================

Name: long_division_arbiter

Overview:
- Round-robin arbiter that shares one long_division_core between NR_OF_REQ_P requesters.
- Each requester presents a dividend/divisor pair on a valid/ready handshake and gets back its quotient and overflow flag on its own response handshake.
- Sits between requester clients (e.g. per-channel DSP blocks) and a single long_division_core instance.
- One division in flight at a time. The result is held until the owning requester accepts it.

Parameters:
- NR_OF_REQ_P, 4, number of requesters (≥2).
- N_BITS_P, 32, operand/quotient width; must match the core.
- Q_BITS_P, 15, fractional bits; passed through for documentation only, not used in logic.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  NR_OF_REQ_P  per-requester operand valid
- req_ready  output  NR_OF_REQ_P  per-requester operand accept (one-hot or zero)
- req_dividend  input  NR_OF_REQ_P*N_BITS_P  flattened dividends; requester i at [i*N_BITS_P +: N_BITS_P]
- req_divisor  input  NR_OF_REQ_P*N_BITS_P  flattened divisors, same packing
- rsp_valid  output  NR_OF_REQ_P  per-requester result valid (one-hot or zero)
- rsp_ready  input  NR_OF_REQ_P  per-requester result accept
- rsp_quotient  output  N_BITS_P  quotient, shared by all requesters, qualified by rsp_valid
- rsp_overflow  output  1  overflow flag, shared, qualified by rsp_valid
- core_valid  output  1  operand strobe to core ing_valid
- core_ready  input  1  core ing_ready
- core_dividend  output  N_BITS_P  to core ing_dividend
- core_divisor  output  N_BITS_P  to core ing_divisor
- core_egr_valid  input  1  core egr_valid (single-cycle pulse)
- core_quotient  input  N_BITS_P  core egr_quotient
- core_overflow  input  1  core egr_overflow
- busy  output  1  high whenever state ≠ IDLE

Behaviour:
- Reset values:
  - FSM = IDLE.
  - req_ready, rsp_valid, core_valid, busy = 0.
  - core_dividend, core_divisor, rsp_quotient, rsp_overflow = 0.
  - Grant register = 0; round-robin pointer last_grant = NR_OF_REQ_P-1, so requester 0 has first priority.
- IDLE:
  - Round-robin search over req_valid, starting at last_grant+1 modulo NR_OF_REQ_P.
  - If any requester is valid, req_ready[g] = 1 combinationally for the winner g only; the handshake completes in that cycle.
  - In the same cycle: register core_dividend/core_divisor from slot g, grant ← g, last_grant ← g, go to ISSUE.
  - If no requester is valid, stay in IDLE.
  - req_ready is never asserted outside IDLE.
- ISSUE:
  - core_valid = 1 (registered).
  - Transfer completes on the first cycle with core_valid && core_ready; then core_valid ← 0 and go to WAIT.
  - core_dividend/core_divisor are held stable while in ISSUE.
- WAIT:
  - core_valid = 0.
  - On core_egr_valid: capture core_quotient → rsp_quotient and core_overflow → rsp_overflow, rsp_valid[grant] ← 1, go to RESP.
- RESP:
  - rsp_valid[grant] is held with quotient and overflow stable.
  - On rsp_valid[grant] && rsp_ready[grant]: rsp_valid ← 0, go to IDLE.
  - rsp_ready of non-granted requesters is ignored.
- Minimum latency, counted from the accept cycle to the earliest accept of the next request: 1 (ISSUE) + core latency + 1 (RESP, with rsp_ready tied high) + 1 (IDLE re-arbitration).
- Fairness: a requester that keeps req_valid asserted is granted within NR_OF_REQ_P grants.
- Simultaneous events:
  - rsp_ready and a new req_valid in the same RESP cycle: the new request is not accepted until the following IDLE cycle.
  - A core_egr_valid outside WAIT is ignored.
- Divisor 0: no special handling; the core result (overflow flag) is forwarded unchanged.
- Reset mid-operation: everything returns to reset values asynchronously and any in-flight result is discarded. The core shares rst_n, so it resets too.
- busy = (state ≠ IDLE), registered.

Test Plan:
- Single request: req0 with dividend 6.0 (Q15 fixed-point), divisor 2.0, rsp_ready tied 1 → req_ready[0] is a 1-cycle pulse; one core_valid handshake; rsp_valid[0] with quotient 3.0, overflow 0; no other rsp_valid bit asserted.
- Round-robin: req0–req3 all held valid, each with distinct operands → grants come in order 0,1,2,3,0; every response carries its own requester's quotient.
- Back-pressure: core_ready held 0 for 5 cycles during ISSUE → core_valid stays 1 and operands stay stable; rsp_ready[2] held 0 for 10 cycles during RESP → rsp_valid[2] and quotient held, no new req_ready.
- Overflow: divisor 0 on req1 → rsp_valid[1] with rsp_overflow = 1.
- Reset mid-operation: assert rst_n = 0 during WAIT → all outputs 0 immediately, busy = 0; after release, req3 is served correctly and the stale result never appears.
- Spurious pulse: inject core_egr_valid while in IDLE → no rsp_valid asserted.

Source files
------------

// File: rtl/long_division_arbiter.sv
// Round-robin arbiter sharing one long_division_core between several requesters.
// One division is in flight at a time; its result is held until the owner accepts it.
module long_division_arbiter #(
    parameter int unsigned NR_OF_REQ_P = 4,
    parameter int unsigned N_BITS_P    = 32,
    parameter int unsigned Q_BITS_P    = 15
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NR_OF_REQ_P-1:0]          req_valid,
    output logic [NR_OF_REQ_P-1:0]          req_ready,
    input  logic [NR_OF_REQ_P*N_BITS_P-1:0] req_dividend,
    input  logic [NR_OF_REQ_P*N_BITS_P-1:0] req_divisor,
    output logic [NR_OF_REQ_P-1:0]          rsp_valid,
    input  logic [NR_OF_REQ_P-1:0]          rsp_ready,
    output logic [N_BITS_P-1:0]             rsp_quotient,
    output logic                            rsp_overflow,
    output logic                            core_valid,
    input  logic                            core_ready,
    output logic [N_BITS_P-1:0]             core_dividend,
    output logic [N_BITS_P-1:0]             core_divisor,
    input  logic                            core_egr_valid,
    input  logic [N_BITS_P-1:0]             core_quotient,
    input  logic                            core_overflow,
    output logic                            busy
);

    localparam int unsigned IDX_W = (NR_OF_REQ_P > 1) ? $clog2(NR_OF_REQ_P) : 1;

    // Q_BITS_P only documents the fixed-point format; reject nonsensical configurations.
    if (NR_OF_REQ_P < 2 || Q_BITS_P >= N_BITS_P) begin : g_param_check
        $error("long_division_arbiter: invalid parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                   state, state_d;
    logic [IDX_W-1:0]         grant, grant_d;
    logic [IDX_W-1:0]         last_grant, last_grant_d;
    logic [IDX_W-1:0]         win, cand;
    logic                     found;
    logic                     core_valid_d;
    logic [N_BITS_P-1:0]      core_dividend_d, core_divisor_d;
    logic [NR_OF_REQ_P-1:0]   rsp_valid_d;
    logic [N_BITS_P-1:0]      rsp_quotient_d;
    logic                     rsp_overflow_d;
    logic                     busy_d;
    logic [NR_OF_REQ_P-1:0]   req_ready_c;

    // Accept strobe is combinational so the winner's handshake closes in the IDLE cycle.
    assign req_ready = req_ready_c;

    // Round-robin search, next-state and next-output logic.
    always_comb begin
        state_d         = state;
        grant_d         = grant;
        last_grant_d    = last_grant;
        core_valid_d    = core_valid;
        core_dividend_d = core_dividend;
        core_divisor_d  = core_divisor;
        rsp_valid_d     = rsp_valid;
        rsp_quotient_d  = rsp_quotient;
        rsp_overflow_d  = rsp_overflow;
        req_ready_c     = '0;
        found           = 1'b0;
        win             = '0;
        cand            = '0;

        // Search starts just after the previous winner so every requester gets its turn.
        for (int unsigned i = 1; i <= NR_OF_REQ_P; i++) begin
            cand = IDX_W'((32'(last_grant) + i) % NR_OF_REQ_P);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end

        case (state)
            ST_IDLE: begin
                if (found) begin
                    req_ready_c[win] = 1'b1;
                    core_dividend_d  = req_dividend[32'(win)*N_BITS_P +: N_BITS_P];
                    core_divisor_d   = req_divisor[32'(win)*N_BITS_P +: N_BITS_P];
                    grant_d          = win;
                    last_grant_d     = win;
                    core_valid_d     = 1'b1;
                    state_d          = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (core_valid && core_ready) begin
                    core_valid_d = 1'b0;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_egr_valid) begin
                    rsp_quotient_d     = core_quotient;
                    rsp_overflow_d     = core_overflow;
                    rsp_valid_d        = '0;
                    rsp_valid_d[grant] = 1'b1;
                    state_d            = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_valid[grant] && rsp_ready[grant]) begin
                    rsp_valid_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            grant         <= '0;
            last_grant    <= IDX_W'(NR_OF_REQ_P - 1);
            core_valid    <= 1'b0;
            core_dividend <= '0;
            core_divisor  <= '0;
            rsp_valid     <= '0;
            rsp_quotient  <= '0;
            rsp_overflow  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            grant         <= grant_d;
            last_grant    <= last_grant_d;
            core_valid    <= core_valid_d;
            core_dividend <= core_dividend_d;
            core_divisor  <= core_divisor_d;
            rsp_valid     <= rsp_valid_d;
            rsp_quotient  <= rsp_quotient_d;
            rsp_overflow  <= rsp_overflow_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_long_division_arbiter.sv
// Scoreboard bench for long_division_arbiter with a behavioural Q15 divider core.
module tb_long_division_arbiter;

    localparam int unsigned NR  = 4;
    localparam int unsigned W   = 32;
    localparam int unsigned LAT = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*W-1:0]   req_dividend;
    logic [NR*W-1:0]   req_divisor;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready;
    logic [W-1:0]      rsp_quotient;
    logic              rsp_overflow;
    logic              core_valid;
    logic              core_ready;
    logic [W-1:0]      core_dividend;
    logic [W-1:0]      core_divisor;
    logic              core_egr_valid;
    logic [W-1:0]      core_quotient;
    logic              core_overflow;
    logic              busy;

    long_division_arbiter #(
        .NR_OF_REQ_P(NR),
        .N_BITS_P   (W),
        .Q_BITS_P   (15)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_quotient  (rsp_quotient),
        .rsp_overflow  (rsp_overflow),
        .core_valid    (core_valid),
        .core_ready    (core_ready),
        .core_dividend (core_dividend),
        .core_divisor  (core_divisor),
        .core_egr_valid(core_egr_valid),
        .core_quotient (core_quotient),
        .core_overflow (core_overflow),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] q;
        logic        ov;
    } op_t;

    typedef struct {
        int          id;
        logic [31:0] q;
        logic        ov;
    } exp_t;

    op_t     pend[$];
    exp_t    sb[$];
    int      grant_log[$];
    int      n_cmp = 0;
    int      n_err = 0;
    int      rdy_cycles[NR];
    int      rsp_count[NR];
    int      core_hs = 0;
    logic    inject_egr;
    logic    cbusy;
    logic    pend_hs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int find_op(input int id);
        foreach (pend[k]) if (pend[k].id == id) return k;
        return -1;
    endfunction

    task automatic dp();
        @(posedge clk);
        #2;
    endtask

    task automatic push_op(input int id, input logic [31:0] dvd, input logic [31:0] dvs,
                           input logic [31:0] q, input logic ov);
        op_t o;
        o.id = id; o.dvd = dvd; o.dvs = dvs; o.q = q; o.ov = ov;
        pend.push_back(o);
    endtask

    function automatic logic idle_all();
        return (pend.size() == 0) && (sb.size() == 0) && !busy && !cbusy && !pend_hs
               && (rsp_valid == '0);
    endfunction

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!idle_all() && t < 500);
        chk({name, "_drain"}, 64'(idle_all()), 64'd1);
    endtask

    task automatic clear_counters();
        for (int i = 0; i < NR; i++) begin
            rdy_cycles[i] = 0;
            rsp_count[i]  = 0;
        end
        core_hs = 0;
        grant_log.delete();
    endtask

    // Reset pulse with checks that every output falls immediately.
    task automatic do_reset();
        dp();
        rst_n = 1'b0;
        pend.delete();
        sb.delete();
        #1;
        chk("rst_busy",          64'(busy),          64'd0);
        chk("rst_rsp_valid",     64'(rsp_valid),     64'd0);
        chk("rst_core_valid",    64'(core_valid),    64'd0);
        chk("rst_core_dividend", 64'(core_dividend), 64'd0);
        chk("rst_core_divisor",  64'(core_divisor),  64'd0);
        chk("rst_rsp_quotient",  64'(rsp_quotient),  64'd0);
        chk("rst_rsp_overflow",  64'(rsp_overflow),  64'd0);
        dp();
        chk("rst_req_ready",     64'(req_ready),     64'd0);
        dp();
        rst_n = 1'b1;
    endtask

    // Requester driver: present the oldest pending op per requester, retire it on handshake.
    initial begin
        logic [NR-1:0] acc;
        int            idx;
        exp_t          e;
        acc          = '0;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                for (int i = 0; i < NR; i++) begin
                    if (acc[i]) begin
                        idx = find_op(i);
                        if (idx >= 0) begin
                            e.id = i; e.q = pend[idx].q; e.ov = pend[idx].ov;
                            sb.push_back(e);
                            grant_log.push_back(i);
                            pend.delete(idx);
                        end
                    end
                end
            end
            acc = '0;
            for (int i = 0; i < NR; i++) begin
                idx = find_op(i);
                if (idx >= 0) begin
                    req_valid[i]          = 1'b1;
                    req_dividend[i*W +: W] = pend[idx].dvd;
                    req_divisor[i*W +: W]  = pend[idx].dvs;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            @(negedge clk);
            acc = rst_n ? (req_valid & req_ready) : '0;
        end
    end

    // Behavioural divider core: fixed latency, Q15 result, saturates with overflow.
    initial begin
        int          cnt;
        logic [63:0] num;
        logic [63:0] q64;
        logic [31:0] c_q;
        logic        c_ov;
        cnt = 0; c_q = '0; c_ov = 1'b0;
        core_egr_valid = 1'b0;
        core_quotient  = '0;
        core_overflow  = 1'b0;
        cbusy          = 1'b0;
        pend_hs        = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            core_egr_valid = 1'b0;
            if (!rst_n) begin
                cbusy   = 1'b0;
                pend_hs = 1'b0;
            end else if (pend_hs) begin
                pend_hs = 1'b0;
                cbusy   = 1'b1;
                cnt     = LAT;
            end else if (cbusy) begin
                cnt--;
                if (cnt == 0) begin
                    core_egr_valid = 1'b1;
                    core_quotient  = c_q;
                    core_overflow  = c_ov;
                    cbusy          = 1'b0;
                end
            end
            if (inject_egr) begin
                core_egr_valid = 1'b1;
                core_quotient  = 32'hDEAD_BEEF;
                core_overflow  = 1'b1;
            end
            @(negedge clk);
            if (rst_n && core_valid && core_ready && !cbusy && !pend_hs) begin
                pend_hs = 1'b1;
                core_hs++;
                num = {32'd0, core_dividend} << 15;
                if (core_divisor == '0) begin
                    c_q  = 32'hFFFF_FFFF;
                    c_ov = 1'b1;
                end else begin
                    q64  = num / {32'd0, core_divisor};
                    c_ov = |q64[63:32];
                    c_q  = c_ov ? 32'hFFFF_FFFF : q64[31:0];
                end
            end
        end
    end

    // Monitor: invariants every cycle, scoreboard pop on each response handshake.
    initial begin
        logic [NR-1:0] fire;
        exp_t          e;
        int            id;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (!$onehot0(rsp_valid)) chk("rsp_valid_onehot0", 64'(rsp_valid), 64'd0);
                if (!$onehot0(req_ready)) chk("req_ready_onehot0", 64'(req_ready), 64'd0);
                if (busy && req_ready != '0) chk("req_ready_while_busy", 64'(req_ready), 64'd0);
                if ((req_ready & ~req_valid) != '0) chk("req_ready_without_valid", 64'(req_ready), 64'd0);
                for (int i = 0; i < NR; i++) if (req_ready[i]) rdy_cycles[i]++;
                fire = rsp_valid & rsp_ready;
                if (fire != '0) begin
                    id = -1;
                    for (int i = 0; i < NR; i++) if (fire[i]) id = i;
                    if (id >= 0) rsp_count[id]++;
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", 64'(fire), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id",       64'(id),           64'(e.id));
                        chk("rsp_quotient", 64'(rsp_quotient), 64'(e.q));
                        chk("rsp_overflow", 64'(rsp_overflow), 64'(e.ov));
                    end
                end
            end
        end
    end

    // Hard stop in case a wait ever fails to terminate.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Directed test sequence.
    initial begin
        int rr_exp[5];
        int t;
        int stale_before;
        rr_exp = '{0, 1, 2, 3, 0};
        rst_n      = 1'b0;
        core_ready = 1'b1;
        rsp_ready  = '1;
        inject_egr = 1'b0;
        clear_counters();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("init_busy",       64'(busy),         64'd0);
        chk("init_rsp_valid",  64'(rsp_valid),    64'd0);
        chk("init_core_valid", 64'(core_valid),   64'd0);
        chk("init_req_ready",  64'(req_ready),    64'd0);
        chk("init_core_dvd",   64'(core_dividend), 64'd0);
        chk("init_rsp_q",      64'(rsp_quotient), 64'd0);

        // Single request: 6.0 / 2.0 = 3.0
        dp();
        clear_counters();
        push_op(0, 32'h0003_0000, 32'h0001_0000, 32'h0001_8000, 1'b0);
        wait_drain("single");
        chk("single_req_ready_cycles", 64'(rdy_cycles[0]), 64'd1);
        chk("single_core_handshakes",  64'(core_hs),       64'd1);
        chk("single_rsp_count",        64'(rsp_count[0]),  64'd1);
        chk("single_other_rsp",        64'(rsp_count[1] + rsp_count[2] + rsp_count[3]), 64'd0);

        // Round-robin from a fresh pointer: grants 0,1,2,3,0
        do_reset();
        dp();
        clear_counters();
        push_op(0, 32'h0005_0000, 32'h0002_0000, 32'h0001_4000, 1'b0);
        push_op(1, 32'h0004_8000, 32'h0001_8000, 32'h0001_8000, 1'b0);
        push_op(2, 32'h0000_8000, 32'h0001_0000, 32'h0000_4000, 1'b0);
        push_op(3, 32'h0003_8000, 32'h0000_8000, 32'h0003_8000, 1'b0);
        push_op(0, 32'h0001_8000, 32'h0002_0000, 32'h0000_6000, 1'b0);
        wait_drain("rr");
        chk("rr_grant_count", 64'(grant_log.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) chk($sformatf("rr_grant_%0d", i), 64'(grant_log[i]), 64'(rr_exp[i]));
        end

        // Back-pressure on the core side and on the response side
        dp();
        core_ready   = 1'b0;
        rsp_ready[2] = 1'b0;
        push_op(2, 32'h0002_8000, 32'h0001_0000, 32'h0001_4000, 1'b0);
        t = 0;
        while (!core_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bp_core_valid_seen", 64'(core_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_core_valid_held", 64'(core_valid),    64'd1);
            chk("bp_dividend_stable", 64'(core_dividend), 64'h0002_8000);
            chk("bp_divisor_stable",  64'(core_divisor),  64'h0001_0000);
        end
        dp();
        core_ready = 1'b1;
        t = 0;
        while (!rsp_valid[2] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("bp_rsp_valid_seen", 64'(rsp_valid[2]), 64'd1);
        dp();
        push_op(0, 32'h0001_0000, 32'h0000_8000, 32'h0001_0000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid_held", 64'(rsp_valid),    64'h4);
            chk("bp_quotient_held",  64'(rsp_quotient), 64'h0001_4000);
            chk("bp_no_req_ready",   64'(req_ready),    64'd0);
        end
        dp();
        rsp_ready[2] = 1'b1;
        wait_drain("bp");

        // Divide by zero on requester 1: overflow forwarded
        dp();
        push_op(1, 32'h0001_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_drain("ovf");

        // Reset while waiting on the core; the stale result must never surface
        dp();
        push_op(0, 32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 1'b0);
        t = 0;
        while (!cbusy && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("midrst_core_busy", 64'(cbusy), 64'd1);
        repeat (2) @(negedge clk);
        stale_before = rsp_count[0];
        do_reset();
        dp();
        push_op(3, 32'h0006_0000, 32'h0002_0000, 32'h0001_8000, 1'b0);
        wait_drain("midrst");
        repeat (20) @(negedge clk);
        chk("midrst_no_stale", 64'(rsp_count[0] - stale_before), 64'd0);

        // Spurious core result pulse while idle
        dp();
        inject_egr = 1'b1;
        dp();
        inject_egr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("spurious_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("spurious_busy",      64'(busy),      64'd0);
        end

        chk("final_scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
